// File: rtl/state_pkg.sv
// Shared pose and jump-phase types for the player-2 motion/animation path.
package state_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEFT1  = 3'd1,
        LEFT2  = 3'd2,
        RIGHT1 = 3'd3,
        RIGHT2 = 3'd4
    } State;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } jump_t;

endpackage

// File: rtl/vga_pkg.sv
// Screen geometry shared by the video pipeline; sprite limits derive from it.
package vga_pkg;

    localparam int H_PIXELS      = 800;
    localparam int V_PIXELS      = 600;
    localparam int SPRITE_W      = 40;
    localparam int X_MAX_DEFAULT = H_PIXELS - SPRITE_W;

endpackage

// File: rtl/player2_frame_tick.sv
// Registers vblnk and emits a one-cycle tick on its rising edge (one tick per frame).
module player2_frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_r;
    logic vblnk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_r <= 1'b0;
            vblnk_d <= 1'b0;
        end else begin
            vblnk_r <= vblnk;
            vblnk_d <= vblnk_r;
        end
    end

    assign tick = vblnk_r & ~vblnk_d;

endmodule

// File: rtl/player2_ctl.sv
// Player-2 motion controller: button sync, horizontal move with clamps, jump FSM
// and walk animation, all advanced once per frame tick.
module player2_ctl
    import state_pkg::*;
#(
    parameter int X_INIT      = 400,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = vga_pkg::X_MAX_DEFAULT,
    parameter int Y_GROUND    = 100,
    parameter int SPEED       = 4,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int ANIM_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos_player2,
    output logic [11:0] ypos_player2,
    output State        state,
    output jump_t       jump_state
);

    localparam int CW = (ANIM_FRAMES > 2) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CW-1:0]      ANIM_LAST = CW'(ANIM_FRAMES - 1);
    localparam logic signed [12:0] X_MIN_S   = 13'(X_MIN);
    localparam logic signed [12:0] X_MAX_S   = 13'(X_MAX);
    localparam logic signed [12:0] SPEED_S   = 13'(SPEED);
    localparam logic signed [12:0] Y_GND_S   = 13'(Y_GROUND);
    localparam logic signed [7:0]  JUMP_V_S  = 8'(JUMP_V);
    localparam logic signed [8:0]  GRAV_S    = 9'(GRAVITY);
    localparam logic signed [8:0]  VY_FLOOR  = -9'sd127;

    logic tick;

    player2_frame_tick u_frame_tick (
        .clk   (clk),
        .rst   (rst),
        .vblnk (vblnk),
        .tick  (tick)
    );

    // Buttons are asynchronous: two flops each, bit order {jump, right, left}.
    logic [2:0] sync1, sync2;
    logic left, right, jump;

    assign left  = sync2[0];
    assign right = sync2[1];
    assign jump  = sync2[2];

    logic [11:0]       x_q, x_d, y_q, y_d;
    logic signed [7:0] vy_q, vy_d;
    jump_t             jump_q, jump_d;
    logic              jump_prev_q, jump_prev_d;
    State              state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            x_q         <= 12'(X_INIT);
            y_q         <= 12'(Y_GROUND);
            vy_q        <= '0;
            jump_q      <= GROUND;
            jump_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
        end else begin
            sync1       <= {btn_jump, btn_right, btn_left};
            sync2       <= sync1;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            jump_q      <= jump_d;
            jump_prev_q <= jump_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    // Horizontal: 13-bit signed so stepping past either screen edge clamps instead of wrapping.
    logic signed [12:0] xs, xn;

    always_comb begin
        x_d = x_q;
        xs  = $signed({1'b0, x_q});
        xn  = xs;
        if (tick) begin
            if (left && !right) begin
                xn = xs - SPEED_S;
                if (xn < X_MIN_S) xn = X_MIN_S;
            end else if (right && !left) begin
                xn = xs + SPEED_S;
                if (xn > X_MAX_S) xn = X_MAX_S;
            end
            x_d = xn[11:0];
        end
    end

    // Jump FSM: the launch tick already applies the first vertical step.
    logic               launch;
    logic signed [7:0]  vy_cur;
    logic signed [8:0]  vy_sub;
    logic signed [12:0] ny;

    always_comb begin
        jump_d      = jump_q;
        y_d         = y_q;
        vy_d        = vy_q;
        jump_prev_d = jump_prev_q;
        launch      = 1'b0;
        vy_cur      = vy_q;
        vy_sub      = '0;
        ny          = '0;
        if (tick) begin
            jump_prev_d = jump;
            launch      = (jump_q == GROUND) && jump && !jump_prev_q;
            if (jump_q == AIR || launch) begin
                vy_cur = launch ? JUMP_V_S : vy_q;
                ny     = $signed({1'b0, y_q}) - {{5{vy_cur[7]}}, vy_cur};
                vy_sub = {vy_cur[7], vy_cur} - GRAV_S;
                if (vy_sub < VY_FLOOR) vy_sub = VY_FLOOR;
                vy_d   = vy_sub[7:0];
                jump_d = AIR;
                if (ny >= Y_GND_S) begin
                    y_d    = 12'(Y_GROUND);
                    vy_d   = '0;
                    jump_d = GROUND;
                end else if (ny < 13'sd0) begin
                    y_d  = '0;
                    vy_d = '0;
                end else begin
                    y_d = ny[11:0];
                end
            end
        end
    end

    // Pose: a fresh direction starts at phase 1; the counter then flips phases every ANIM_FRAMES ticks.
    State d1, d2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d1      = left ? LEFT1 : RIGHT1;
        d2      = left ? LEFT2 : RIGHT2;
        if (tick) begin
            if (left ^ right) begin
                if (state_q != d1 && state_q != d2) begin
                    state_d = d1;
                    cnt_d   = '0;
                end else if (cnt_q == ANIM_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == d1) ? d2 : d1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    assign xpos_player2 = x_q;
    assign ypos_player2 = y_q;
    assign state        = state_q;
    assign jump_state   = jump_q;

endmodule

// File: tb/tb_player2_ctl.sv
// Randomized and directed bench for player2_ctl with a frame-level reference model and scoreboard.
module tb_player2_ctl;
    import state_pkg::*;

    localparam int W = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic        chk_req = 1'b0;
    logic [11:0] xpos_player2;
    logic [11:0] ypos_player2;
    State        state;
    jump_t       jump_state;

    player2_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .vblnk        (vblnk),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .xpos_player2 (xpos_player2),
        .ypos_player2 (ypos_player2),
        .state        (state),
        .jump_state   (jump_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    // Reference model: position as integers, jump as closed-form height from ticks airborne,
    // pose from the length of the current same-direction run.
    int m_x, m_y, m_k, m_dir, m_run;
    bit m_air, m_prev;

    task automatic model_reset();
        m_x = 400; m_y = 100; m_k = 0; m_dir = 0; m_run = 0;
        m_air = 1'b0; m_prev = 1'b0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j);
        int h;
        if (l != r) begin
            if (l) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
            else   m_x = (m_x + 4 > 760) ? 760 : m_x + 4;
            if (m_dir == (l ? 1 : 2)) m_run++;
            else begin m_dir = l ? 1 : 2; m_run = 1; end
        end else begin
            m_dir = 0; m_run = 0;
        end
        if (!m_air && j && !m_prev) begin m_air = 1'b1; m_k = 0; end
        m_prev = j;
        if (m_air) begin
            m_k++;
            h = 12 * m_k - (m_k * (m_k - 1)) / 2;
            if (h <= 0) begin m_y = 100; m_air = 1'b0; end
            else if (h > 100) m_y = 0;
            else m_y = 100 - h;
        end
    endtask

    function automatic logic [W-1:0] model_pack();
        State  p;
        jump_t js;
        bit    ph;
        ph = (((m_run - 1) / 8) % 2) == 1;
        if (m_dir == 0)      p = IDLE;
        else if (m_dir == 1) p = ph ? LEFT2 : LEFT1;
        else                 p = ph ? RIGHT2 : RIGHT1;
        js = m_air ? AIR : GROUND;
        return {12'(m_x), 12'(m_y), p, js};
    endfunction

    task automatic push_exp(input string nm);
        exp_q.push_back(model_pack());
        name_q.push_back(nm);
    endtask

    task automatic do_frame(input bit l, input bit r, input bit j, input string nm);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_jump = j;
        repeat (4) @(negedge clk);
        model_frame(l, r, j);
        push_exp(nm);
        vblnk = 1'b1;
        repeat (6) @(negedge clk);
        vblnk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_now(input string nm);
        @(negedge clk);
        push_exp(nm);
        chk_req = 1'b1;
        @(negedge clk);
        chk_req = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: outputs settle two clocks after a vblnk rise; sample well after that.
    initial begin
        logic [W-1:0] act, exp;
        string nm;
        forever begin
            @(posedge vblnk or posedge chk_req);
            repeat (4) @(posedge clk);
            @(negedge clk);
            act = {xpos_player2, ypos_player2, state, jump_state};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expected: actual x=%0d y=%0d st=%0d j=%0d, no entry queued",
                         act[27:16], act[15:4], act[3:1], act[0]);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s: actual x=%0d y=%0d st=%0d j=%0d expected x=%0d y=%0d st=%0d j=%0d",
                             nm, act[27:16], act[15:4], act[3:1], act[0],
                             exp[27:16], exp[15:4], exp[3:1], exp[0]);
                end
            end
        end
    end

    initial begin
        int n;
        bit l, r, j;
        model_reset();
        do_reset(3);
        check_now("reset");
        for (int i = 0; i < 5; i++) do_frame(0, 0, 0, "idle_hold");

        for (int i = 0; i < 20; i++) do_frame(0, 1, 0, "walk_right");
        while (m_x < 756) do_frame(0, 1, 0, "run_to_edge");
        for (int i = 0; i < 5; i++) do_frame(0, 1, 0, "clamp_right");
        for (int i = 0; i < 2; i++) do_frame(1, 1, 0, "both_idle");
        while (m_x > 0) do_frame(1, 0, 0, "run_left");
        for (int i = 0; i < 12; i++) do_frame(1, 0, 0, "clamp_left");

        @(negedge clk);
        btn_right = 1'b1; btn_left = 1'b0;
        repeat (30) @(negedge clk);
        check_now("no_tick");

        do_frame(0, 0, 1, "jump_start");
        for (int i = 0; i < 28; i++) do_frame(0, 0, 0, "jump_arc");

        for (int i = 0; i < 32; i++) do_frame(0, 0, 1, "held_jump");
        do_frame(0, 0, 0, "release");
        do_frame(0, 0, 1, "repress");
        for (int i = 0; i < 6; i++) do_frame(0, 1, (i % 2) == 1, "air_press");
        for (int i = 0; i < 22; i++) do_frame(0, 1, 0, "air_walk");

        do_frame(1, 0, 1, "jump_left");
        for (int i = 0; i < 5; i++) do_frame(1, 0, 0, "pre_reset");
        do_reset(1);
        check_now("reset_mid_jump");

        n = 300;
        for (int i = 0; i < n; i++) begin
            l = $urandom_range(0, 3) == 0 ? 1'b0 : ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 2) == 0;
            j = $urandom_range(0, 5) == 0;
            do_frame(l, r, j, "random");
        end

        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
